counter_display_ctrl: RTL and testbench



---
 rtl/counter_display_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_counter_display_ctrl.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_display_ctrl.sv
// N-digit hex/BCD up/down counter stepped by a debounced button or an auto-rate tick,
// shown on a multiplexed active-low seven-segment display. Single clock, tick enables only.
module counter_display_ctrl #(
    parameter int NUM_DIGITS      = 4,
    parameter int SCAN_DIV        = 50000,
    parameter int COUNT_DIV       = 50000000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  button,
    input  logic                  mode_select,
    input  logic                  count_down,
    input  logic                  bcd_mode,
    input  logic                  clear,
    output logic [NUM_DIGITS-1:0] digit_select,
    output logic [6:0]            seven,
    output logic                  wrap
);

    localparam int CW = 4 * NUM_DIGITS;
    localparam int SW = $clog2(SCAN_DIV);
    localparam int AW = $clog2(COUNT_DIV);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [SW-1:0] scan_cnt;
    logic [AW-1:0] auto_cnt;
    logic          scan_tick;
    logic          auto_tick;

    logic          sync1;
    logic          sync2;
    logic          deb_level;
    logic          deb_prev;
    logic [DW-1:0] deb_cnt;
    logic          press;

    logic          bcd_prev;
    logic          radix_change;
    logic          step;

    logic [CW-1:0] count;
    logic [CW-1:0] stepped;
    logic [CW-1:0] count_next;
    logic          carry;
    logic [3:0]    nib;
    logic [3:0]    max_nib;

    logic [IW-1:0]         scan_idx;
    logic [IW-1:0]         idx_next;
    logic [NUM_DIGITS-1:0] sel_next;
    logic [3:0]            shown_nib;

    function automatic logic [6:0] decode(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign scan_tick = (scan_cnt == SW'(SCAN_DIV - 1));
    assign auto_tick = (auto_cnt == AW'(COUNT_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_cnt <= '0;
            auto_cnt <= '0;
        end else begin
            scan_cnt <= scan_tick ? '0 : scan_cnt + SW'(1);
            auto_cnt <= auto_tick ? '0 : auto_cnt + AW'(1);
        end
    end

    // The level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1     <= 1'b0;
            sync2     <= 1'b0;
            deb_level <= 1'b0;
            deb_prev  <= 1'b0;
            deb_cnt   <= '0;
        end else begin
            sync1    <= button;
            sync2    <= sync1;
            deb_prev <= deb_level;
            if (sync2 != deb_level) begin
                if (deb_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
                    deb_level <= sync2;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + DW'(1);
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    assign press        = deb_level & ~deb_prev;
    assign step         = mode_select ? auto_tick : press;
    assign radix_change = bcd_mode ^ bcd_prev;

    // Per-nibble ripple; hex is the same chain with a limit of 15.
    always_comb begin
        stepped = count;
        carry   = 1'b1;
        nib     = '0;
        max_nib = bcd_mode ? 4'd9 : 4'd15;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            nib = count[4*i +: 4];
            if (carry) begin
                if (count_down) begin
                    if (nib == 4'd0) begin
                        stepped[4*i +: 4] = max_nib;
                    end else begin
                        stepped[4*i +: 4] = nib - 4'd1;
                        carry             = 1'b0;
                    end
                end else begin
                    if (nib == max_nib) begin
                        stepped[4*i +: 4] = 4'd0;
                    end else begin
                        stepped[4*i +: 4] = nib + 4'd1;
                        carry             = 1'b0;
                    end
                end
            end
        end
    end

    always_comb begin
        count_next = count;
        if (clear || radix_change) begin
            count_next = '0;
        end else if (step) begin
            count_next = stepped;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            bcd_prev <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            count    <= count_next;
            bcd_prev <= bcd_mode;
            wrap     <= ~clear & ~radix_change & step & carry;
        end
    end

    // Segments are decoded from the next count and next index so they stay aligned with the anode.
    always_comb begin
        idx_next  = scan_idx;
        sel_next  = '1;
        shown_nib = '0;
        if (scan_tick) begin
            idx_next = (scan_idx == IW'(NUM_DIGITS - 1)) ? '0 : scan_idx + IW'(1);
        end
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (IW'(i) == idx_next) begin
                sel_next[i] = 1'b0;
                shown_nib   = count_next[4*i +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            scan_idx     <= '0;
            digit_select <= {{(NUM_DIGITS-1){1'b1}}, 1'b0};
            seven        <= 7'b1000000;
        end else begin
            scan_idx     <= idx_next;
            digit_select <= sel_next;
            seven        <= decode(shown_nib);
        end
    end

endmodule

// File: tb/tb_counter_display_ctrl.sv
// Randomised and directed bench for counter_display_ctrl against an arithmetic reference model.
module tb_counter_display_ctrl;

    localparam int N_DIG = 2;
    localparam int SCAN  = 4;
    localparam int CDIV  = 8;
    localparam int DEB   = 3;
    localparam int HEX_MAX = (1 << (4 * N_DIG)) - 1;
    localparam int DEC_MAX = (N_DIG == 1) ? 9 : (N_DIG == 2) ? 99 : (N_DIG == 3) ? 999 : 9999;

    logic             clk = 1'b0;
    logic             reset;
    logic             button;
    logic             mode_select;
    logic             count_down;
    logic             bcd_mode;
    logic             clear;
    logic [N_DIG-1:0] digit_select;
    logic [6:0]       seven;
    logic             wrap;

    counter_display_ctrl #(
        .NUM_DIGITS(N_DIG), .SCAN_DIV(SCAN), .COUNT_DIV(CDIV), .DEBOUNCE_CYCLES(DEB)
    ) dut (
        .clk(clk), .reset(reset), .button(button), .mode_select(mode_select),
        .count_down(count_down), .bcd_mode(bcd_mode), .clear(clear),
        .digit_select(digit_select), .seven(seven), .wrap(wrap)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;
    int wrap_seen = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: the count is held as an integer value and stepped arithmetically.
    int m_cyc, m_count, m_idx, m_deb, m_deb_prev, m_run, m_h1, m_h2, m_bcd_prev, m_wrap, m_steps;
    int sv, v;
    bit s_tick, c_tick, m_press, m_step;

    function automatic int to_dec(input int c);
        int r = 0, p = 1;
        for (int i = 0; i < N_DIG; i++) begin
            r += ((c >> (4 * i)) & 15) * p;
            p *= 10;
        end
        return r;
    endfunction

    function automatic int to_bcd(input int d);
        int r = 0;
        for (int i = 0; i < N_DIG; i++) begin
            r |= (d % 10) << (4 * i);
            d /= 10;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_cyc = 0; m_count = 0; m_idx = 0; m_deb = 0; m_deb_prev = 0; m_run = 0;
            m_h1 = 0; m_h2 = 0; m_bcd_prev = 0; m_wrap = 0;
        end else begin
            s_tick = (m_cyc % SCAN) == SCAN - 1;
            c_tick = (m_cyc % CDIV) == CDIV - 1;
            m_cyc++;
            sv = m_h2; m_h2 = m_h1; m_h1 = int'(button);
            m_press = (m_deb == 1) && (m_deb_prev == 0);
            m_deb_prev = m_deb;
            if (sv != m_deb) begin
                m_run++;
                if (m_run == DEB) begin m_deb = sv; m_run = 0; end
            end else begin
                m_run = 0;
            end
            m_step = mode_select ? c_tick : m_press;
            m_wrap = 0;
            if (clear || int'(bcd_mode) != m_bcd_prev) begin
                m_count = 0;
            end else if (m_step) begin
                m_steps++;
                if (bcd_mode) begin
                    v = to_dec(m_count);
                    if (count_down) begin
                        if (v == 0) begin v = DEC_MAX; m_wrap = 1; end else v--;
                    end else begin
                        if (v == DEC_MAX) begin v = 0; m_wrap = 1; end else v++;
                    end
                    m_count = to_bcd(v);
                end else begin
                    if (count_down) begin
                        if (m_count == 0) m_wrap = 1;
                        m_count = (m_count + HEX_MAX) % (HEX_MAX + 1);
                    end else begin
                        if (m_count == HEX_MAX) m_wrap = 1;
                        m_count = (m_count + 1) % (HEX_MAX + 1);
                    end
                end
            end
            m_bcd_prev = int'(bcd_mode);
            if (s_tick) m_idx = (m_idx + 1) % N_DIG;
        end
    end

    always @(posedge clk) if (wrap === 1'b1) wrap_seen++;

    logic [N_DIG-1:0] e_sel;
    always @(negedge clk) begin
        if (chk_en) begin
            e_sel = '1;
            e_sel[m_idx] = 1'b0;
            check_eq("wrap", wrap, m_wrap);
            check_eq("digit_select", digit_select, e_sel);
            check_eq("seven", seven, seg_tab[(m_count >> (4 * m_idx)) & 15]);
        end
    end

    task automatic tick_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_steps(input int n);
        int target = m_steps + n;
        int budget = CDIV * n * 2 + 20;
        mode_select = 1'b1;
        while (m_steps < target && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        mode_select = 1'b0;
        check_eq("step_timeout", budget > 0, 1);
    endtask

    task automatic align_tick();
        int budget = CDIV + 2;
        while ((m_cyc % CDIV) != CDIV - 1 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
    endtask

    task automatic read_display(input string tag, input logic [31:0] exp);
        int d [N_DIG];
        int got = 0;
        int idx;
        bit bad = 1'b0;
        for (int i = 0; i < N_DIG; i++) d[i] = -1;
        repeat (2 * SCAN * N_DIG + 2) begin
            @(negedge clk);
            idx = -1;
            for (int i = 0; i < N_DIG; i++) if (digit_select[i] == 1'b0) idx = i;
            if (idx >= 0) begin
                d[idx] = -1;
                for (int k = 0; k < 16; k++) if (seg_tab[k] === seven) d[idx] = k;
            end
        end
        for (int i = 0; i < N_DIG; i++) begin
            if (d[i] < 0) bad = 1'b1;
            else got |= d[i] << (4 * i);
        end
        check_eq(tag, bad ? 32'hDEAD_BEEF : 32'(got), exp);
    endtask

    task automatic reset_and_check(input string tag);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk_en = 1'b1;
        check_eq({tag, "_dsel"}, digit_select, 2'b10);
        check_eq({tag, "_seven"}, seven, 7'b1000000);
        check_eq({tag, "_wrap"}, wrap, 0);
        reset = 1'b0;
    endtask

    int hold;

    initial begin
        reset = 1'b0; button = 1'b0; mode_select = 1'b0; count_down = 1'b0;
        bcd_mode = 1'b0; clear = 1'b0;
        reset_and_check("reset");
        tick_n(12);

        // Hex wrap down then up.
        count_down = 1'b1;
        wrap_seen = 0;
        wait_steps(2);
        tick_n(2);
        read_display("hex_fe", 32'hFE);
        check_eq("hex_wrap_dn0", wrap_seen, 1);
        count_down = 1'b0;
        wrap_seen = 0;
        wait_steps(2);
        tick_n(2);
        read_display("hex_00", 32'h00);
        check_eq("hex_wrap_up", wrap_seen, 1);
        wait_steps(1);
        count_down = 1'b1;
        tick_n(2);
        wrap_seen = 0;
        wait_steps(2);
        tick_n(2);
        read_display("hex_ff", 32'hFF);
        check_eq("hex_wrap_dn", wrap_seen, 1);

        // BCD.
        bcd_mode = 1'b1;
        tick_n(2);
        read_display("bcd_clr", 32'h00);
        wait_steps(2);
        count_down = 1'b0;
        tick_n(2);
        read_display("bcd_98", 32'h98);
        wrap_seen = 0;
        wait_steps(1);
        tick_n(2);
        read_display("bcd_99", 32'h99);
        check_eq("bcd_nowrap", wrap_seen, 0);
        wait_steps(1);
        tick_n(2);
        read_display("bcd_00", 32'h00);
        check_eq("bcd_wrap", wrap_seen, 1);
        wait_steps(10);
        tick_n(2);
        read_display("bcd_10", 32'h10);
        count_down = 1'b1;
        wait_steps(1);
        tick_n(2);
        read_display("bcd_09", 32'h09);

        // Button path in hex.
        bcd_mode = 1'b0;
        count_down = 1'b0;
        tick_n(2);
        button = 1'b1; tick_n(1);
        button = 1'b0; tick_n(1);
        button = 1'b1; tick_n(10);
        read_display("btn_press", 32'h01);
        button = 1'b0; tick_n(10);
        read_display("btn_release", 32'h01);
        button = 1'b1; tick_n(2);
        button = 1'b0; tick_n(10);
        read_display("btn_glitch", 32'h01);

        // Clear coincident with an auto step.
        wrap_seen = 0;
        mode_select = 1'b1;
        align_tick();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        mode_select = 1'b0;
        tick_n(2);
        read_display("clr_step", 32'h00);
        check_eq("clr_nowrap", wrap_seen, 0);

        // Radix change coincident with an auto step.
        wait_steps(1);
        mode_select = 1'b1;
        align_tick();
        bcd_mode = 1'b1;
        @(negedge clk);
        mode_select = 1'b0;
        tick_n(2);
        read_display("radix_step", 32'h00);
        check_eq("radix_nowrap", wrap_seen, 0);

        // Reset mid-count at 0x37.
        bcd_mode = 1'b0;
        count_down = 1'b0;
        tick_n(2);
        wait_steps(55);
        tick_n(2);
        read_display("hex_37", 32'h37);
        reset_and_check("midreset");
        read_display("after_reset", 32'h00);

        // Random phase checked each cycle against the model.
        hold = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (hold == 0) begin
                button = 1'($urandom_range(0, 1));
                hold = $urandom_range(1, 8);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 63) == 0) mode_select = ~mode_select;
            if ($urandom_range(0, 15) == 0) count_down = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 127) == 0) bcd_mode = ~bcd_mode;
            clear = ($urandom_range(0, 99) == 0);
            reset = ($urandom_range(0, 999) == 0);
        end
        @(negedge clk);
        reset = 1'b0;
        clear = 1'b0;
        tick_n(4);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
